// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnd_pkg
// Purpose  : Glyph table, message codes and FSM state type for the FND driver.
// Revision : 1.0
// ============================================================================
package fnd_pkg;

    localparam logic [7:0] GLYPH_0     = 8'h3F;
    localparam logic [7:0] GLYPH_1     = 8'h06;
    localparam logic [7:0] GLYPH_2     = 8'h5B;
    localparam logic [7:0] GLYPH_3     = 8'h4F;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'h6D;
    localparam logic [7:0] GLYPH_6     = 8'h7D;
    localparam logic [7:0] GLYPH_7     = 8'h07;
    localparam logic [7:0] GLYPH_8     = 8'h7F;
    localparam logic [7:0] GLYPH_9     = 8'h6F;
    localparam logic [7:0] GLYPH_A     = 8'h77;
    localparam logic [7:0] GLYPH_B     = 8'h7C;
    localparam logic [7:0] GLYPH_C     = 8'h39;
    localparam logic [7:0] GLYPH_D     = 8'h5E;
    localparam logic [7:0] GLYPH_E     = 8'h79;
    localparam logic [7:0] GLYPH_H     = 8'h76;
    localparam logic [7:0] GLYPH_I     = 8'h10;
    localparam logic [7:0] GLYPH_L     = 8'h38;
    localparam logic [7:0] GLYPH_N     = 8'h54;
    localparam logic [7:0] GLYPH_O     = 8'h5C;
    localparam logic [7:0] GLYPH_P     = 8'h73;
    localparam logic [7:0] GLYPH_R     = 8'h50;
    localparam logic [7:0] GLYPH_T     = 8'h78;
    localparam logic [7:0] GLYPH_U     = 8'h1C;
    localparam logic [7:0] GLYPH_V     = 8'h3E;
    localparam logic [7:0] GLYPH_Y     = 8'h6E;
    localparam logic [7:0] GLYPH_MINUS = 8'h40;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    localparam logic [31:0] MSG_BLANK = 32'h00CC_0000;
    localparam logic [31:0] MSG_ERROR = 32'h00EE_0000;
    localparam logic [31:0] MSG_PLUS  = 32'h0010_0000;
    localparam logic [31:0] MSG_MINUS = 32'h0020_0000;
    localparam logic [31:0] MSG_MUL   = 32'h0030_0000;
    localparam logic [31:0] MSG_DIV   = 32'h0040_0000;
    localparam logic [31:0] MSG_MOD   = 32'h0050_0000;
    localparam logic [31:0] MSG_HAPPY = 32'h00A0_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } fnd_state_e;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = GLYPH_0;
            4'd1:    digit_glyph = GLYPH_1;
            4'd2:    digit_glyph = GLYPH_2;
            4'd3:    digit_glyph = GLYPH_3;
            4'd4:    digit_glyph = GLYPH_4;
            4'd5:    digit_glyph = GLYPH_5;
            4'd6:    digit_glyph = GLYPH_6;
            4'd7:    digit_glyph = GLYPH_7;
            4'd8:    digit_glyph = GLYPH_8;
            4'd9:    digit_glyph = GLYPH_9;
            default: digit_glyph = GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic is_msg_code(input logic [31:0] code);
        case (code)
            MSG_BLANK, MSG_ERROR, MSG_PLUS, MSG_MINUS,
            MSG_MUL, MSG_DIV, MSG_MOD, MSG_HAPPY: is_msg_code = 1'b1;
            default:                             is_msg_code = 1'b0;
        endcase
    endfunction

    // Six glyphs, leftmost character in the top byte (lands in digit 5).
    function automatic logic [47:0] msg_glyphs(input logic [31:0] code);
        case (code)
            MSG_ERROR: msg_glyphs = {GLYPH_BLANK, GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_O, GLYPH_R};
            MSG_PLUS:  msg_glyphs = {GLYPH_BLANK, GLYPH_P, GLYPH_L, GLYPH_U, GLYPH_5, GLYPH_BLANK};
            MSG_MINUS: msg_glyphs = {GLYPH_N, GLYPH_N, GLYPH_1, GLYPH_N, GLYPH_U, GLYPH_5};
            MSG_MUL:   msg_glyphs = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_N, GLYPH_N, GLYPH_U, GLYPH_L};
            MSG_DIV:   msg_glyphs = {GLYPH_BLANK, GLYPH_0, GLYPH_I, GLYPH_V, GLYPH_I, GLYPH_0};
            MSG_MOD:   msg_glyphs = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_N, GLYPH_N, GLYPH_O, GLYPH_D};
            MSG_HAPPY: msg_glyphs = {GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P, GLYPH_Y, GLYPH_BLANK};
            default:   msg_glyphs = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_driver_n_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter, one bit per clock.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
    parameter int DATA_W     = 32,
    parameter int BCD_DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [DATA_W-1:0]       i_bin,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic                    r_run;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_adj;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                  r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end

    // High during the final shift; o_bcd holds the result from the next cycle.
    assign o_done = r_run && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_bin <= '0;
            r_bcd <= '0;
        end else if (i_start && !r_run) begin
            r_run <= 1'b1;
            r_cnt <= CNT_W'(DATA_W);
            r_bin <= i_bin;
            r_bcd <= '0;
        end else if (r_run) begin
            r_bcd <= {w_adj[4*BCD_DIGITS-2:0], r_bin[DATA_W-1]};
            r_bin <= {r_bin[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_driver_n.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_driver_n
// Purpose  : Multiplexed N-digit 7-segment driver with sequential BCD encode.
//            FND_BLINK_EN adds blink_mask input and BLINK_DIV per-digit blinking.
// Revision : 1.0
// ============================================================================
module fnd_scan_driver_n import fnd_pkg::*; #(
    parameter int DIGITS         = 6,
    parameter int DATA_W         = 32,
    parameter int SCAN_DIV       = 1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
`ifdef FND_BLINK_EN
    , parameter int BLINK_DIV    = 64
`endif
) (
    input  logic              fnd_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] fnd_serial,
`ifdef FND_BLINK_EN
    input  logic [DIGITS-1:0] blink_mask,
`endif
    output logic              busy,
    output logic [DIGITS-1:0] fnd_s,
    output logic [7:0]        fnd_d
);

    localparam int BCD_DIGITS = (DATA_W * 302) / 1000 + 1;
    localparam int IDX_W      = $clog2(DIGITS);
    localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [63:0] C_ERR_PAD = {40'h0, GLYPH_E, GLYPH_R, GLYPH_R};

    fnd_state_e               r_state;
    logic                     r_neg;
    logic                     r_msg_sel;
    logic [47:0]              r_msg;
    logic [DIGITS-1:0][7:0]   r_buf;
    logic [IDX_W-1:0]         r_idx;
    logic [PRE_W-1:0]         r_pre;

    logic [63:0]              w_serial_ext;
    logic                     w_is_msg;
    logic [DATA_W-1:0]        w_abs;
    logic                     w_start;
    logic                     w_bcd_done;
    logic [4*BCD_DIGITS-1:0]  w_bcd;
    logic [4*BCD_DIGITS+31:0] w_bcd_pad;
    logic [63:0]              w_msg_pad;
    logic [DIGITS-1:0][7:0]   w_msg_buf;
    logic [DIGITS-1:0][7:0]   w_num_buf;
    logic                     w_ovf;
    logic [3:0]               w_msd;
    logic                     w_pre_wrap;
    logic [DIGITS-1:0]        w_onehot;
    logic [7:0]               w_seg;

    assign w_serial_ext = 64'(fnd_serial);
    assign w_is_msg     = (w_serial_ext[63:32] == 32'h0) && is_msg_code(w_serial_ext[31:0]);
    assign w_abs        = fnd_serial[DATA_W-1] ? (~fnd_serial + DATA_W'(1)) : fnd_serial;
    assign w_start      = (r_state == ST_IDLE) && load && !w_is_msg;
    assign w_bcd_pad    = {32'h0, w_bcd};
    assign w_msg_pad    = {16'h0, r_msg};

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (fnd_clk),
        .rst     (rst),
        .i_start (w_start),
        .i_bin   (w_abs),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_msg_buf = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_msg_buf[i] = w_msg_pad[8*i +: 8];
        end
    end

    // Leading-zero blanking, sign placement and overflow detection.
    always_comb begin
        w_ovf     = 1'b0;
        w_msd     = 4'd0;
        w_num_buf = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w_bcd_pad[4*i +: 4] != 4'd0) begin
                if (i >= DIGITS) w_ovf = 1'b1;
                if (r_neg && (i >= DIGITS - 1)) w_ovf = 1'b1;
                if (i < DIGITS) w_msd = 4'(i);
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (4'(i) <= w_msd) begin
                w_num_buf[i] = digit_glyph(w_bcd_pad[4*i +: 4]);
            end else if (r_neg && (4'(i) == w_msd + 4'd1)) begin
                w_num_buf[i] = GLYPH_MINUS;
            end
        end
        if (w_ovf) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_num_buf[i] = C_ERR_PAD[8*i +: 8];
            end
        end
    end

    always_ff @(posedge fnd_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            r_neg     <= 1'b0;
            r_msg_sel <= 1'b0;
            r_msg     <= '0;
            r_buf     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        busy      <= 1'b1;
                        r_neg     <= fnd_serial[DATA_W-1];
                        r_msg_sel <= w_is_msg;
                        r_msg     <= msg_glyphs(w_serial_ext[31:0]);
                        r_state   <= w_is_msg ? ST_ENCODE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_bcd_done) begin
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    r_buf   <= r_msg_sel ? w_msg_buf : w_num_buf;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_pre_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_onehot   = DIGITS'(1) << r_idx;

`ifdef FND_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0] r_frame;
    logic             r_phase;

    always_ff @(posedge fnd_clk) begin
        if (rst) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_pre_wrap && (r_idx == IDX_W'(DIGITS - 1))) begin
            if (r_frame == BLK_W'(BLINK_DIV - 1)) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + BLK_W'(1);
            end
        end
    end

    assign w_seg = (r_phase && blink_mask[r_idx]) ? 8'h00 : r_buf[r_idx];
`else
    assign w_seg = r_buf[r_idx];
`endif

    always_ff @(posedge fnd_clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
            fnd_s <= SEL_ACTIVE_LOW ? '1 : '0;
            fnd_d <= 8'h00;
        end else begin
            fnd_s <= SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
            fnd_d <= w_seg;
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
